phase_stepper: RTL and testbench
================================

# phase_stepper

Upstream phase generator for the sine/cosine lookup stage. Produces a registered `degree` stream in tenths of a degree (0..3599), advancing once per clock by a programmable fixed-point step and wrapping modulo 3600. It also supplies the `iscos` select so the lookup stage can emit continuous sine or cosine waveforms at software-chosen frequencies, either free-running or as a single sweep.

## Interface
- `PHASE_MAX`, 3600: phase modulus, in tenths of a degree.
- `DEG_W`, 12: width of the integer phase and step.
- `FRAC_W`, 8: fractional phase bits, in units of 1/256 of a tenth-degree.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin generating (sampled in IDLE only).
- `stop` in 1: abort generation.
- `sweep` in 1: latched at start; 1 = stop after one full revolution.
- `iscos_in` in 1: latched at start; forwarded as `iscos`.
- `phase_init` in DEG_W: starting phase, latched at start.
- `step_valid` in 1: new step offered.
- `step_int` in DEG_W: integer part of the step.
- `step_frac` in FRAC_W: fractional part of the step.
- `step_ready` out 1: step accepted when `step_valid & step_ready`.
- `degree` out DEG_W: current phase, 0..3599, to the LUT.
- `iscos` out 1: cosine select, to the LUT.
- `sample_valid` out 1: `degree` is a live sample.
- `wrap` out 1: one-cycle pulse on the sample where the phase wrapped past 3599.
- `done` out 1: one-cycle pulse when a sweep completes.

## Operation
- States:
  - IDLE: `step_ready`=1; `degree` holds its last value.
  - RUN: samples are generated.
  - DONE: lasts one cycle, then returns to IDLE.
- IDLE→RUN:
  - Condition: `start`=1 and `stop`=0. If `start` and `stop` are both high, `stop` wins and the block stays in IDLE.
  - On the entry edge: accumulator ← {clamp(`phase_init`), 0}; `iscos` ← `iscos_in`; sweep flag ← `sweep`.
- Per-cycle update in RUN:
  - acc_next = acc + {step_int_r, step_frac_r}.
  - If the integer part of acc_next is ≥ 3600, subtract 3600 and assert `wrap` on that sample.
- Clamp rule: any `phase_init` or `step_int` ≥ 3600 is clamped to 3599 when captured.
- Step loading:
  - `step_ready`=1 in IDLE and RUN, and 0 in DONE.
  - An accepted step is registered on the acceptance edge and is used from the following update onward.
  - The reset step is 1.0 (`step_int`=1, `step_frac`=0).
  - A step of 0 is legal: `degree` stays constant while `sample_valid` remains 1.
- `stop` in RUN: next state is IDLE. No update occurs on that edge; `degree` holds its value.
- Sweep mode:
  - The update that would wrap is suppressed; `degree` holds the last pre-wrap value.
  - State goes to DONE and `done` pulses.
  - `wrap` is not asserted.
- `stop` and a sweep wrap in the same cycle: `stop` wins; the block goes to IDLE and `done` does not pulse.
- Reset values: state IDLE, `degree`=0, accumulator fraction=0, `iscos`=0, `sample_valid`=0, `wrap`=0, `done`=0, `step_ready`=0 during reset and 1 in the cycle after, step register=1.0.
- Reset mid-run: abandons the run immediately; all outputs take their reset values on that edge.

## Timing
- All outputs are registered.
- Start accepted at edge N: `degree`=clamp(`phase_init`) and `sample_valid`=1 after edge N.
- Each subsequent edge produces one new sample, so throughput is 1 sample/clk.
- `wrap` is coincident with the wrapped `degree` value.
- `done` is high for exactly the cycle spent in DONE; `sample_valid` is 0 in DONE.
- Downstream LUT latency is not compensated here; `iscos` and `degree` change on the same edge.

## Structure
- Shared package `trig_pkg`: `PHASE_MAX`=3600, `DEG_W`=12, `VAL_W`=10, `FRAC_W`=8, and the state enum {IDLE, RUN, DONE}. The lookup stage uses the same package.
- One combinational sub-module, `phase_wrap_add`:
  - Inputs: acc, step.
  - Outputs: acc_next, wrapped.
  - Behaviour: fixed-point add with modulo-3600 correction on the integer part.
- The FSM, clamp logic and step register live in `phase_stepper`.

## Test plan
- Reset, then start with `phase_init`=0, step 1.0, `sweep`=0 → `degree` = 0,1,2,…,3599,0. `wrap` pulses only on the sample where `degree` returns to 0.
- Load step `step_int`=0, `step_frac`=128 (0.5), then start → `degree` = 0,0,1,1,2,2,…; `step_ready`=1 throughout.
- `phase_init`=3598, `step_int`=4000 (clamped to 3599) → `degree` = 3598, 3597, 3596; `wrap` is asserted every cycle.
- Sweep with `phase_init`=3590, step 5 → `degree` = 3590, 3595; DONE follows with `done`=1 and `sample_valid`=0; then IDLE with `degree`=3595.
- In IDLE, `start`=`stop`=1 → the block stays in IDLE with `sample_valid`=0. In RUN with `degree`=100, assert `stop` → the next cycle is IDLE with `degree`=100.
- Assert `rst` mid-run at `degree`=1234 with `iscos`=1 → next cycle `degree`=0, `iscos`=0, `sample_valid`=0, step reset to 1.0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared constants, FSM state type and phase clamp helper for the phase
// generator and the sine/cosine lookup stage.
package trig_pkg;
    localparam int PHASE_MAX = 3600;
    localparam int DEG_W     = 12;
    localparam int VAL_W     = 10;
    localparam int FRAC_W    = 8;
    localparam int ACC_W     = DEG_W + FRAC_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Out-of-range phases and steps saturate to the last legal tenth-degree.
    function automatic logic [DEG_W-1:0] clamp_deg(input logic [DEG_W-1:0] v);
        if (v >= DEG_W'(PHASE_MAX))
            return DEG_W'(PHASE_MAX - 1);
        return v;
    endfunction
endpackage

// File: rtl/phase_wrap_add.sv
// Fixed-point phase accumulate with modulo-3600 correction on the integer part.
module phase_wrap_add
    import trig_pkg::*;
(
    input  logic [ACC_W-1:0] acc_i,
    input  logic [ACC_W-1:0] step_i,
    output logic [ACC_W-1:0] acc_next_o,
    output logic             wrapped_o
);
    localparam logic [DEG_W:0] MOD = (DEG_W + 1)'(PHASE_MAX);

    logic [ACC_W:0] sum;
    logic [DEG_W:0] sum_int;

    // Both operands stay below 3600, so one subtraction always lands in range.
    always_comb begin
        sum        = {1'b0, acc_i} + {1'b0, step_i};
        sum_int    = sum[ACC_W:FRAC_W];
        wrapped_o  = (sum_int >= MOD);
        if (wrapped_o)
            sum_int = sum_int - MOD;
        acc_next_o = {sum_int[DEG_W-1:0], sum[FRAC_W-1:0]};
    end
endmodule

// File: rtl/phase_stepper.sv
// Phase generator for the trig LUT: steps a tenth-degree phase by a programmable
// fixed-point increment, free-running or as one sweep, with registered outputs.
module phase_stepper
    import trig_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              sweep,
    input  logic              iscos_in,
    input  logic [DEG_W-1:0]  phase_init,
    input  logic              step_valid,
    input  logic [DEG_W-1:0]  step_int,
    input  logic [FRAC_W-1:0] step_frac,
    output logic              step_ready,
    output logic [DEG_W-1:0]  degree,
    output logic              iscos,
    output logic              sample_valid,
    output logic              wrap,
    output logic              done,
    output state_t            dbg_state
);
    state_t           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] step_q;
    logic             wrapped;
    logic             sweep_q;
    logic             iscos_q;
    logic             sample_valid_q;
    logic             wrap_q;
    logic             done_q;
    logic             step_ready_q;

    phase_wrap_add u_add (
        .acc_i      (acc_q),
        .step_i     (step_q),
        .acc_next_o (acc_d),
        .wrapped_o  (wrapped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            acc_q          <= '0;
            step_q         <= {DEG_W'(1), FRAC_W'(0)};
            sweep_q        <= 1'b0;
            iscos_q        <= 1'b0;
            sample_valid_q <= 1'b0;
            wrap_q         <= 1'b0;
            done_q         <= 1'b0;
            step_ready_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            // A step accepted now only affects updates after this edge.
            if (step_valid && step_ready_q)
                step_q <= {clamp_deg(step_int), step_frac};

            case (state_q)
                IDLE: begin
                    step_ready_q   <= 1'b1;
                    sample_valid_q <= 1'b0;
                    if (start && !stop) begin
                        state_q        <= RUN;
                        acc_q          <= {clamp_deg(phase_init), FRAC_W'(0)};
                        iscos_q        <= iscos_in;
                        sweep_q        <= sweep;
                        sample_valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    step_ready_q <= 1'b1;
                    if (stop) begin
                        state_q        <= IDLE;
                        sample_valid_q <= 1'b0;
                    end else if (wrapped && sweep_q) begin
                        // Sweep ends on the last pre-wrap sample; the phase holds.
                        state_q        <= DONE;
                        sample_valid_q <= 1'b0;
                        done_q         <= 1'b1;
                        step_ready_q   <= 1'b0;
                    end else begin
                        acc_q          <= acc_d;
                        wrap_q         <= wrapped;
                        sample_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q        <= IDLE;
                    step_ready_q   <= 1'b1;
                    sample_valid_q <= 1'b0;
                end
                default: begin
                    state_q        <= IDLE;
                    sample_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign degree       = acc_q[ACC_W-1:FRAC_W];
    assign iscos        = iscos_q;
    assign sample_valid = sample_valid_q;
    assign wrap         = wrap_q;
    assign done         = done_q;
    assign step_ready   = step_ready_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_phase_stepper.sv
// Bench for phase_stepper: directed sequences with literal expectations plus a
// randomized run compared every cycle against a phase-in-1/256-units model.
module tb_phase_stepper;
    localparam int FULL = 3600 * 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        sweep = 1'b0;
    logic        iscos_in = 1'b0;
    logic [11:0] phase_init = '0;
    logic        step_valid = 1'b0;
    logic [11:0] step_int = '0;
    logic [7:0]  step_frac = '0;
    logic        step_ready;
    logic [11:0] degree;
    logic        iscos;
    logic        sample_valid;
    logic        wrap;
    logic        done;
    logic [1:0]  dbg_state;

    phase_stepper dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .sweep        (sweep),
        .iscos_in     (iscos_in),
        .phase_init   (phase_init),
        .step_valid   (step_valid),
        .step_int     (step_int),
        .step_frac    (step_frac),
        .step_ready   (step_ready),
        .degree       (degree),
        .iscos        (iscos),
        .sample_valid (sample_valid),
        .wrap         (wrap),
        .done         (done),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: phase and step in units of 1/256 tenth-degree.
    int m_mode;   // 0 idle, 1 generating, 2 sweep-finished cycle
    int m_phase;
    int m_step;
    bit m_sweep;
    bit m_accept;
    int m_new_step;
    int m_n;
    int exp_degree;
    bit exp_iscos, exp_sv, exp_wrap, exp_done, exp_ready;

    function automatic int clamp(int v);
        return (v >= 3600) ? 3599 : v;
    endfunction

    always @(posedge clk) begin
        m_accept   = step_valid && exp_ready;
        m_new_step = clamp(int'(step_int)) * 256 + int'(step_frac);
        if (rst) begin
            m_mode = 0; m_phase = 0; m_step = 256; m_sweep = 0;
            exp_iscos = 0; exp_sv = 0; exp_wrap = 0; exp_done = 0; exp_ready = 0;
        end else begin
            exp_wrap = 0;
            exp_done = 0;
            if (m_mode == 0) begin
                exp_sv = 0;
                if (start && !stop) begin
                    m_mode    = 1;
                    m_phase   = clamp(int'(phase_init)) * 256;
                    exp_iscos = iscos_in;
                    m_sweep   = sweep;
                    exp_sv    = 1;
                end
            end else if (m_mode == 1) begin
                m_n = m_phase + m_step;
                if (stop) begin
                    m_mode = 0;
                    exp_sv = 0;
                end else if (m_n >= FULL && m_sweep) begin
                    m_mode   = 2;
                    exp_done = 1;
                    exp_sv   = 0;
                end else if (m_n >= FULL) begin
                    m_phase  = m_n - FULL;
                    exp_wrap = 1;
                end else begin
                    m_phase = m_n;
                end
            end else begin
                m_mode = 0;
                exp_sv = 0;
            end
            exp_ready = (m_mode != 2);
            if (m_accept)
                m_step = m_new_step;
        end
        exp_degree = m_phase / 256;
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("m_degree", degree, exp_degree);
            check("m_iscos", iscos, exp_iscos);
            check("m_sample_valid", sample_valid, exp_sv);
            check("m_wrap", wrap, exp_wrap);
            check("m_done", done, exp_done);
            check("m_step_ready", step_ready, exp_ready);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_step(input int si, input int sf);
        step_valid = 1'b1; step_int = si[11:0]; step_frac = sf[7:0];
        cyc();
        step_valid = 1'b0;
    endtask

    task automatic do_start(input int init, input bit sw, input bit ic);
        start = 1'b1; phase_init = init[11:0]; sweep = sw; iscos_in = ic;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    int half_seq[6] = '{0, 0, 1, 1, 2, 2};

    initial begin
        // Reset
        cyc();
        cyc();
        check_en = 1'b1;
        check("rst_degree", degree, 0);
        check("rst_sample_valid", sample_valid, 0);
        check("rst_step_ready", step_ready, 0);
        check("rst_iscos", iscos, 0);
        check("rst_done", done, 0);
        check("rst_wrap", wrap, 0);
        rst = 1'b0;
        cyc();
        check("ready_after_rst", step_ready, 1);

        // Full revolution at step 1.0
        do_start(0, 1'b0, 1'b0);
        check("rev_first", degree, 0);
        check("rev_first_valid", sample_valid, 1);
        check("rev_first_wrap", wrap, 0);
        for (int i = 1; i <= 3600; i++) begin
            cyc();
            check("rev_degree", degree, i % 3600);
            check("rev_wrap", wrap, (i == 3600) ? 1 : 0);
        end
        do_stop();

        // Half-step
        load_step(0, 128);
        do_start(0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            check("half_degree", degree, half_seq[i]);
            check("half_ready", step_ready, 1);
            cyc();
        end
        do_stop();

        // Clamped step wraps every cycle
        load_step(4000, 0);
        do_start(3598, 1'b0, 1'b1);
        check("clamp_d0", degree, 3598);
        check("clamp_iscos", iscos, 1);
        cyc();
        check("clamp_d1", degree, 3597);
        check("clamp_w1", wrap, 1);
        cyc();
        check("clamp_d2", degree, 3596);
        check("clamp_w2", wrap, 1);
        do_stop();

        // Single sweep
        load_step(5, 0);
        do_start(3590, 1'b1, 1'b0);
        check("sweep_d0", degree, 3590);
        cyc();
        check("sweep_d1", degree, 3595);
        cyc();
        check("sweep_done", done, 1);
        check("sweep_done_valid", sample_valid, 0);
        check("sweep_done_degree", degree, 3595);
        check("sweep_done_ready", step_ready, 0);
        check("sweep_no_wrap", wrap, 0);
        cyc();
        check("sweep_idle_done", done, 0);
        check("sweep_idle_degree", degree, 3595);
        check("sweep_idle_ready", step_ready, 1);

        // start and stop together, then stop mid-run
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        check("startstop_valid", sample_valid, 0);
        do_start(100, 1'b0, 1'b0);
        check("stop_pre", degree, 100);
        do_stop();
        check("stop_degree", degree, 100);
        check("stop_valid", sample_valid, 0);

        // Reset mid-run
        do_start(1234, 1'b0, 1'b1);
        check("rr_degree", degree, 1234);
        check("rr_iscos", iscos, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check("rr_deg0", degree, 0);
        check("rr_iscos0", iscos, 0);
        check("rr_valid0", sample_valid, 0);
        check("rr_ready0", step_ready, 0);
        cyc();
        do_start(10, 1'b0, 1'b0);
        check("rr_start", degree, 10);
        cyc();
        check("rr_step1", degree, 11);
        do_stop();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 20000; c++) begin
            rst        = ($urandom_range(0, 399) == 0);
            start      = ($urandom_range(0, 3) == 0);
            stop       = ($urandom_range(0, 23) == 0);
            sweep      = $urandom_range(0, 1);
            iscos_in   = $urandom_range(0, 1);
            phase_init = 12'($urandom_range(0, 4095));
            step_valid = ($urandom_range(0, 7) == 0);
            step_int   = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 20))
                                                     : 12'($urandom_range(0, 4095));
            step_frac  = 8'($urandom_range(0, 255));
            cyc();
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; step_valid = 1'b0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
